// File: rtl/seg_disp_sched.sv
// seg_disp_sched: round-robin time-multiplexing scheduler for the 8-digit
// 7-segment display. Each requester holds the display for DWELL cycles per
// grant; the display word tracks the granted slot's data live.
// Optional feature macro: SEG_SLOT_TAG_EN (slot index shown on leftmost digit).
//
// Handshake: REQ is a level, not a pulse. A slot keeps REQ high for as long
// as it wants the display; GNT is the registered one-hot answer, DONE pulses
// for one cycle when a full dwell completes, and dropping REQ while granted
// abandons the grant at the next edge with no DONE.
module seg_disp_sched #(
   parameter int NREQ  = 4,
   parameter int DWELL = 1024,
   parameter int CNT_W = 20
) (
   input  logic                 CLK,
   input  logic                 RST_X,
   input  logic [NREQ-1:0]      REQ,
   input  logic [32*NREQ-1:0]   DATA,
   input  logic                 HOLD,
   output logic [31:0]          DISP_DATA,
   output logic [NREQ-1:0]      GNT,
   output logic [NREQ-1:0]      DONE,
   output logic                 BUSY
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {ST_IDLE, ST_SHOW} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     gidx_q, gidx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       disp_q, disp_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              busy_q, busy_d;

   logic [PW-1:0]     nxt_ptr;
   logic [PW-1:0]     arb_base;
   logic [PW-1:0]     arb_idx;
   logic              arb_found;
   logic              rel_drop, rel_exp;
   logic [31:0]       arb_word, cur_word;

   // Display word for a slot: raw data, or tagged with the slot index.
   function automatic logic [31:0] slot_word(input logic [32*NREQ-1:0] data,
                                             input logic [PW-1:0] idx);
      logic [31:0] w;
      w = data[32*idx +: 32];
`ifdef SEG_SLOT_TAG_EN
      w[31:28] = {{(4-PW){1'b0}}, idx};
`endif
      return w;
   endfunction

   // Release conditions for the current grant and the rotated pointer.
   always_comb begin
      nxt_ptr  = (gidx_q == PW'(NREQ-1)) ? '0 : gidx_q + 1'b1;
      rel_drop = (state_q == ST_SHOW) && !REQ[gidx_q];
      rel_exp  = (state_q == ST_SHOW) && REQ[gidx_q] && !HOLD &&
                 (cnt_q == CNT_W'(DWELL-1));
      arb_base = (state_q == ST_SHOW) ? nxt_ptr : ptr_q;
   end

   // Round-robin search from arb_base; lowest offset with REQ set wins.
   always_comb begin
      logic [PW:0] sum;
      arb_found = 1'b0;
      arb_idx   = '0;
      sum       = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         sum = {1'b0, arb_base} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
         if (REQ[sum[PW-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = sum[PW-1:0];
         end
      end
      arb_word = slot_word(DATA, arb_idx);
      cur_word = slot_word(DATA, gidx_q);
   end

   // Next-state logic for the IDLE/SHOW scheduler.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               state_d = ST_SHOW;
               gidx_d  = arb_idx;
               gnt_d   = NREQ'(1) << arb_idx;
               busy_d  = 1'b1;
               cnt_d   = '0;
               disp_d  = arb_word;
            end
         end
         default: begin
            if (rel_drop || rel_exp) begin
               ptr_d = nxt_ptr;
               // A drop on the expiry cycle suppresses DONE (rel_exp needs REQ).
               if (rel_exp) done_d = NREQ'(1) << gidx_q;
               if (arb_found) begin
                  gidx_d = arb_idx;
                  gnt_d  = NREQ'(1) << arb_idx;
                  cnt_d  = '0;
                  disp_d = arb_word;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
               end
            end else begin
               if (!HOLD) cnt_d = cnt_q + 1'b1;
               disp_d = cur_word;
            end
         end
      endcase
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign DISP_DATA = disp_q;
   assign GNT       = gnt_q;
   assign DONE      = done_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: reference model of the scheduling rules checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_seg_disp_sched;

   localparam int NREQ  = 4;
   localparam int DWELL = 8;
   localparam int CNT_W = 4;

   // ---------------- clock / reset ----------------
   logic               clk = 1'b0;
   logic               rst_x;
   logic [NREQ-1:0]    req;
   logic [32*NREQ-1:0] data;
   logic               hold;
   logic [31:0]        disp_data;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic               busy;

   always #5 clk = ~clk;

   seg_disp_sched #(.NREQ(NREQ), .DWELL(DWELL), .CNT_W(CNT_W)) dut (
      .CLK(clk), .RST_X(rst_x), .REQ(req), .DATA(data), .HOLD(hold),
      .DISP_DATA(disp_data), .GNT(gnt), .DONE(done), .BUSY(busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic cmp_en = 1'b0;

   // ---------------- reference model ----------------
   typedef struct {
      int          g;      // granted slot, -1 when idle
      int          cnt;    // cycles shown so far in this grant
      int          ptr;    // round-robin start point
      logic [31:0] disp;
      int          done;   // slot pulsing DONE, -1 for none
   } model_t;

   model_t m;

   function automatic int arb(logic [NREQ-1:0] r, int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [31:0] shown(logic [32*NREQ-1:0] d, int s);
      logic [31:0] w;
      w = d[32*s +: 32];
`ifdef SEG_SLOT_TAG_EN
      w[31:28] = 4'(s);
`endif
      return w;
   endfunction

   function automatic model_t model_next(model_t s, logic rx, logic [NREQ-1:0] r,
                                         logic [32*NREQ-1:0] d, logic h);
      model_t n;
      int w;
      bit give_up;
      n = s;
      n.done = -1;
      if (!rx) begin
         n.g = -1; n.cnt = 0; n.ptr = 0; n.disp = '0;
         return n;
      end
      give_up = 0;
      if (s.g < 0) begin
         w = arb(r, s.ptr);
         if (w >= 0) begin n.g = w; n.cnt = 0; n.disp = shown(d, w); end
         return n;
      end
      if (!r[s.g]) begin
         give_up = 1;
      end else if (!h && s.cnt == DWELL - 1) begin
         give_up = 1;
         n.done = s.g;
      end
      if (give_up) begin
         n.ptr = (s.g + 1) % NREQ;
         w = arb(r, n.ptr);
         n.g = w;
         n.cnt = 0;
         if (w >= 0) n.disp = shown(d, w);
      end else begin
         if (!h) n.cnt = s.cnt + 1;
         n.disp = shown(d, s.g);
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_next(m, rst_x, req, data, hold);

   // ---------------- scoreboard / compare ----------------
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_gnt",  32'(gnt),  (m.g  >= 0) ? (32'd1 << m.g)    : 32'd0);
         chk("model_done", 32'(done), (m.done >= 0) ? (32'd1 << m.done) : 32'd0);
         chk("model_busy", 32'(busy), (m.g  >= 0) ? 32'd1 : 32'd0);
         chk("model_disp", disp_data, m.disp);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_slot(int s, logic [31:0] v);
      data[32*s +: 32] = v;
   endtask

   task automatic do_reset();
      req   = '0;
      rst_x = 1'b0;
      tick(2);
      rst_x = 1'b1;
      tick(1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_x = 1'b0;
      req   = 4'b1111;
      hold  = 1'b0;
      data  = '0;
      set_slot(0, 32'h1234_5678);
      set_slot(1, 32'h1111_1111);
      set_slot(2, 32'hFFFF_FFFF);
      set_slot(3, 32'h3333_3333);

      // Reset held 3 cycles with all requests asserted.
      tick(1);
      cmp_en = 1'b1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_disp", disp_data, 32'd0);
      tick(2);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst_x = 1'b1;
      tick(1);
      chk("rel_gnt", 32'(gnt), 32'h1);

      // Single requester: slot 0 re-granted every dwell, no gap.
      do_reset();
      req = 4'b0001;
      tick(1);
      chk("single_gnt", 32'(gnt), 32'h1);
      chk("single_disp", disp_data, 32'h1234_5678);
      tick(7);
      chk("single_nodone", 32'(done), 32'h0);
      tick(1);
      chk("single_done", 32'(done), 32'h1);
      chk("single_nogap", 32'(gnt), 32'h1);
      tick(8);
      chk("single_done2", 32'(done), 32'h1);

      // Round-robin over slots 0,1,3 with live data tracking.
      do_reset();
      req = 4'b1011;
      tick(1);
      chk("rr_g0", 32'(gnt), 32'h1);
      tick(8);
      chk("rr_g1", 32'(gnt), 32'h2);
      chk("rr_d0", 32'(done), 32'h1);
      tick(4);
      set_slot(1, 32'hCAFE_F00D);
      tick(1);
      chk("rr_live", disp_data, 32'hCAFE_F00D);
      tick(3);
      chk("rr_g3", 32'(gnt), 32'h8);
      chk("rr_d1", 32'(done), 32'h2);
      tick(8);
      chk("rr_g0b", 32'(gnt), 32'h1);
      chk("rr_d3", 32'(done), 32'h8);

      // Drop slot 1 at cnt=3: grant moves to slot 3, no DONE.
      tick(8);
      chk("drop_g1", 32'(gnt), 32'h2);
      tick(3);
      req = 4'b1001;
      tick(1);
      chk("drop_g3", 32'(gnt), 32'h8);
      chk("drop_nodone", 32'(done), 32'h0);
      chk("drop_disp", disp_data, 32'h3333_3333);
      // Drop slot 3 exactly on its expiry cycle: still no DONE.
      tick(7);
      req = 4'b0001;
      tick(1);
      chk("dropexp_gnt", 32'(gnt), 32'h1);
      chk("dropexp_nodone", 32'(done), 32'h0);

      // HOLD for 5 cycles stretches the grant to 13 cycles.
      tick(2);
      hold = 1'b1;
      tick(5);
      hold = 1'b0;
      tick(5);
      chk("hold_nodone", 32'(done), 32'h0);
      tick(1);
      chk("hold_done", 32'(done), 32'h1);

      // All requests off: idle, display retains last value.
      req = 4'b0000;
      tick(1);
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      tick(3);
      chk("idle_disp", disp_data, 32'h1234_5678);

      // HOLD in idle is ignored; slot 2 wins from pointer 1.
      hold = 1'b1;
      req  = 4'b0100;
      tick(1);
      chk("s2_gnt", 32'(gnt), 32'h4);
`ifdef SEG_SLOT_TAG_EN
      chk("s2_disp_tag", disp_data, 32'h2FFF_FFFF);
`else
      chk("s2_disp", disp_data, 32'hFFFF_FFFF);
`endif
      hold = 1'b0;
      tick(10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
